ifu_iccm_arb_ctl: RTL and testbench
===================================

// Module: ifu_iccm_arb_ctl
// PURPOSE
//  Arbiter/sequencer in front of the banked ICCM array, sharing one port between IFU fetch reads and DMA accesses.
//  Generates SECDED check bits for DMA writes and runs read-modify-write for sub-word DMA stores.
//  Returns steered DMA read data.
//  Sits between ifu_ifc/dma_ctrl and the ICCM memory; drives its wren/rden/rw_addr/wr_size/wr_data.
// PARAMETERS
//  ICCM_BITS       16  byte-address width of ICCM (addr ports are [ICCM_BITS-1:2])
//  DMA_MAX_CONSEC  4   max back-to-back DMA grants while fetch waits; then fetch gets one grant
// PORTS
//  clk              in   1         core clock
//  rst_l            in   1         reset, asynchronous, active-low
//  ifc_rd_req       in   1         fetch read request; held until ifc_rd_gnt
//  ifc_rd_addr      in   ICCM-2    fetch word address [ICCM_BITS-1:2]
//  ifc_rd_gnt       out  1         fetch granted this cycle (comb)
//  ifc_rd_valid     out  1         fetch read data valid on iccm_rd_data (1 cycle after gnt)
//  dma_req          in   1         DMA request; held with payload until dma_gnt
//  dma_wr           in   1         1=write, 0=read
//  dma_addr         in   ICCM-0    DMA byte address [ICCM_BITS-1:0]
//  dma_size         in   3         0=B,1=H,2=W,3=DW
//  dma_wdata        in   64        DMA write data, right-justified per lane
//  dma_gnt          out  1         DMA request accepted (comb)
//  dma_rvalid       out  1         DMA read data/err valid (1-cycle pulse)
//  dma_rdata        out  64        DMA read data (raw, no correction)
//  dma_err          out  1         misaligned access response, with dma_rvalid
//  iccm_wren        out  1         to ICCM array
//  iccm_rden        out  1         to ICCM array
//  iccm_rw_addr     out  ICCM-2    to ICCM array
//  iccm_wr_size     out  3         to ICCM array (2'b11 in [1:0] = both 39b lanes)
//  iccm_wr_data     out  78        {ecc1,data1,ecc0,data0}, 7b ECC per 32b
//  iccm_rd_data     in   156       ICCM array output, valid 1 cycle after rden
// BEHAVIOUR
//  - Reset: all outputs 0; state=IDLE; consec_cnt=0.
//  - States: IDLE, RMW_WR, RESP.
//  - IDLE grant priority: DMA over fetch, unless consec_cnt==DMA_MAX_CONSEC and ifc_rd_req -> fetch.
//  - consec_cnt: +1 per DMA grant while ifc_rd_req=1, saturating; cleared on fetch grant or when ifc_rd_req=0.
//  - Misaligned: H with addr[0], W with addr[1:0]!=0, DW with addr[2:0]!=0.
//    On dma_gnt: no array access; next cycle dma_rvalid=1, dma_err=1, dma_rdata=0.
//  - DMA read: rden, addr=dma_addr[ICCM_BITS-1:2]. Next cycle dma_rvalid=1.
//    dma_rdata = 64b lane pair selected by addr_q[3]; data only, ECC stripped;
//    W returns the word at addr_q[2] zero-extended.
//  - DMA W/DW write: single-cycle wren.
//    W: wr_size=2, data+ECC replicated in both 39b lanes.
//    DW: wr_size=3.
//    No dma_rvalid for writes.
//  - DMA B/H write (RMW): grant cycle issues rden, addr latched -> RMW_WR.
//    RMW_WR: merge bytes into the word selected by addr_q[3:2], regenerate ECC, wren, wr_size=2 -> IDLE.
//    ifc_rd_gnt=0 and dma_gnt=0 in RMW_WR.
//  - ifc_rd_valid and dma_rvalid never both 1 (one access per cycle).
//  - iccm_rden and iccm_wren mutually exclusive every cycle.
//  - RESP: one-cycle state used only for the error response; grants blocked; -> IDLE.
//  - Reset mid-RMW: write abandoned, no partial write issued after rst_l deasserts.
// STRUCTURE
//  - Shared package constants: ICCM_ECC_W=7, size encodings (SZ_B/H/W/DW), arb state enum.
//  - One sub-module: iccm_ecc_gen (comb 32b -> 7b SECDED).
//    Instantiated twice, for the lo and hi lanes.
// TESTING
//  - Fetch-only, addr 0x10 -> gnt same cycle, rden=1, ifc_rd_valid next cycle.
//  - DMA DW write addr 0x08, data 0x1122334455667788 -> wren, wr_size=3, correct ECC in both lanes.
//    A later DMA read returns the same 64b.
//  - DMA B write 0xAB to addr 0x05 over word 0xDEADBEEF -> rden, then wren next cycle with 0xDEADABEF and new ECC.
//    Fetch held off for 2 cycles.
//  - DMA and fetch both requesting continuously, DMA_MAX_CONSEC=4 -> grant pattern D,D,D,D,F repeating.
//  - DMA W read at addr 0x06 -> dma_gnt, no rden, dma_rvalid+dma_err next cycle, rdata=0.
//  - rst_l asserted in RMW_WR -> outputs 0 immediately, IDLE after release, no wren.

Source files
------------

// File: rtl/ifu_iccm_arb_ctl_pkg.sv
// Shared ICCM arbiter types: ECC/lane widths, DMA size codes, arbiter states
// and the DMA alignment rule.
package ifu_iccm_arb_ctl_pkg;

  localparam int ICCM_ECC_W  = 7;
  localparam int ICCM_LANE_W = 32 + ICCM_ECC_W;

  typedef enum logic [1:0] {
    SZ_B  = 2'd0,
    SZ_H  = 2'd1,
    SZ_W  = 2'd2,
    SZ_DW = 2'd3
  } dma_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_WR = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  function automatic logic is_misaligned(input dma_size_e size, input logic [2:0] addr);
    logic mis;
    case (size)
      SZ_H:    mis = addr[0];
      SZ_W:    mis = (addr[1:0] != 2'b00);
      SZ_DW:   mis = (addr != 3'b000);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ifu_iccm_arb_ctl_if.sv
// Fetch, DMA and ICCM-array signals around the arbiter; master is the
// requester/array side, slave is the arbiter.
interface ifu_iccm_arb_ctl_if #(
  parameter int ICCM_BITS = 16
);
  logic                   ifc_rd_req;
  logic [ICCM_BITS-1:2]   ifc_rd_addr;
  logic                   ifc_rd_gnt;
  logic                   ifc_rd_valid;

  logic                   dma_req;
  logic                   dma_wr;
  logic [ICCM_BITS-1:0]   dma_addr;
  logic [2:0]             dma_size;
  logic [63:0]            dma_wdata;
  logic                   dma_gnt;
  logic                   dma_rvalid;
  logic [63:0]            dma_rdata;
  logic                   dma_err;

  logic                   iccm_wren;
  logic                   iccm_rden;
  logic [ICCM_BITS-1:2]   iccm_rw_addr;
  logic [2:0]             iccm_wr_size;
  logic [77:0]            iccm_wr_data;
  logic [155:0]           iccm_rd_data;

  modport master (
    output ifc_rd_req, ifc_rd_addr, dma_req, dma_wr, dma_addr, dma_size, dma_wdata, iccm_rd_data,
    input  ifc_rd_gnt, ifc_rd_valid, dma_gnt, dma_rvalid, dma_rdata, dma_err,
           iccm_wren, iccm_rden, iccm_rw_addr, iccm_wr_size, iccm_wr_data
  );

  modport slave (
    input  ifc_rd_req, ifc_rd_addr, dma_req, dma_wr, dma_addr, dma_size, dma_wdata, iccm_rd_data,
    output ifc_rd_gnt, ifc_rd_valid, dma_gnt, dma_rvalid, dma_rdata, dma_err,
           iccm_wren, iccm_rden, iccm_rw_addr, iccm_wr_size, iccm_wr_data
  );
endinterface

// File: rtl/ifu_iccm_arb_ctl_ecc.sv
// Combinational SECDED check-bit generator: 32 data bits -> 6 Hamming bits
// plus an overall parity bit.
module iccm_ecc_gen
  import ifu_iccm_arb_ctl_pkg::*;
(
  input  logic [31:0]           data,
  output logic [ICCM_ECC_W-1:0] ecc
);

  logic [5:0] hamming;

  // Masks select the data bits whose Hamming position (1..38, parity at powers of two) has bit j set.
  always_comb begin
    hamming[0] = ^(data & 32'h56AA_AD5B);
    hamming[1] = ^(data & 32'h9B33_366D);
    hamming[2] = ^(data & 32'hE3C3_C78E);
    hamming[3] = ^(data & 32'h03FC_07F0);
    hamming[4] = ^(data & 32'h03FF_F800);
    hamming[5] = ^(data & 32'hFC00_0000);
    ecc        = {^{data, hamming}, hamming};
  end

endmodule

// File: rtl/ifu_iccm_arb_ctl.sv
// Single-port ICCM arbiter: DMA-over-fetch priority with a starvation limit,
// ECC generation for DMA writes and read-modify-write for byte/halfword stores.
module ifu_iccm_arb_ctl
  import ifu_iccm_arb_ctl_pkg::*;
#(
  parameter int ICCM_BITS      = 16,
  parameter int DMA_MAX_CONSEC = 4
) (
  input logic               clk,
  input logic               rst_l,
  ifu_iccm_arb_ctl_if.slave bus
);

  localparam int               CNT_W   = $clog2(DMA_MAX_CONSEC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DMA_MAX_CONSEC);
  localparam int               LW      = ICCM_LANE_W;

  arb_state_e           state, state_nxt;
  logic [CNT_W-1:0]     consec_cnt, consec_nxt;
  logic                 fetch_q, dma_rd_q;
  logic [ICCM_BITS-1:0] addr_q;
  dma_size_e            size_q;
  logic [15:0]          wdata_q;

  dma_size_e            req_size;
  logic                 mis;
  logic [31:0]          rmw_word, merged, ecc_lo_in;
  logic [63:0]          lane_pair;
  logic [6:0]           ecc_lo, ecc_hi;
  logic                 rd_ecc_unused;

  // Size codes above DW are illegal and get the same error response as a misaligned access.
  assign req_size = dma_size_e'(bus.dma_size[1:0]);
  assign mis      = bus.dma_size[2] | is_misaligned(req_size, bus.dma_addr[2:0]);

  assign ecc_lo_in = (state == RMW_WR) ? merged : bus.dma_wdata[31:0];

  iccm_ecc_gen u_ecc_lo (.data(ecc_lo_in),            .ecc(ecc_lo));
  iccm_ecc_gen u_ecc_hi (.data(bus.dma_wdata[63:32]), .ecc(ecc_hi));

  always_comb begin
    unique case (addr_q[3:2])
      2'd0: rmw_word = bus.iccm_rd_data[0*LW +: 32];
      2'd1: rmw_word = bus.iccm_rd_data[1*LW +: 32];
      2'd2: rmw_word = bus.iccm_rd_data[2*LW +: 32];
      2'd3: rmw_word = bus.iccm_rd_data[3*LW +: 32];
    endcase
    merged = rmw_word;
    if (size_q == SZ_B) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  assign lane_pair = addr_q[3] ? {bus.iccm_rd_data[3*LW +: 32], bus.iccm_rd_data[2*LW +: 32]}
                               : {bus.iccm_rd_data[1*LW +: 32], bus.iccm_rd_data[0*LW +: 32]};

  // DMA reads return raw data; the stored check bits are intentionally dropped.
  assign rd_ecc_unused = ^{bus.iccm_rd_data[3*LW+32 +: 7], bus.iccm_rd_data[2*LW+32 +: 7],
                           bus.iccm_rd_data[1*LW+32 +: 7], bus.iccm_rd_data[0*LW+32 +: 7]};

  assign bus.ifc_rd_valid = fetch_q;
  assign bus.dma_rvalid   = dma_rd_q | (state == RESP);
  assign bus.dma_err      = (state == RESP);
  assign bus.dma_rdata    = !dma_rd_q        ? 64'b0 :
                            (size_q == SZ_W) ? {32'b0, addr_q[2] ? lane_pair[63:32] : lane_pair[31:0]} :
                                               lane_pair;

  always_comb begin
    state_nxt         = state;
    consec_nxt        = consec_cnt;
    bus.ifc_rd_gnt    = 1'b0;
    bus.dma_gnt       = 1'b0;
    bus.iccm_rden     = 1'b0;
    bus.iccm_wren     = 1'b0;
    bus.iccm_rw_addr  = '0;
    bus.iccm_wr_size  = 3'b000;
    bus.iccm_wr_data  = '0;
    if (rst_l) begin
      unique case (state)
        IDLE: begin
          if (bus.dma_req && !(bus.ifc_rd_req && consec_cnt == CNT_MAX)) begin
            bus.dma_gnt = 1'b1;
            if (mis) begin
              state_nxt = RESP;
            end else if (!bus.dma_wr) begin
              bus.iccm_rden    = 1'b1;
              bus.iccm_rw_addr = bus.dma_addr[ICCM_BITS-1:2];
            end else if (req_size == SZ_W || req_size == SZ_DW) begin
              bus.iccm_wren    = 1'b1;
              bus.iccm_rw_addr = bus.dma_addr[ICCM_BITS-1:2];
              bus.iccm_wr_size = {1'b0, req_size};
              bus.iccm_wr_data = (req_size == SZ_DW)
                ? {ecc_hi, bus.dma_wdata[63:32], ecc_lo, bus.dma_wdata[31:0]}
                : {ecc_lo, bus.dma_wdata[31:0],  ecc_lo, bus.dma_wdata[31:0]};
            end else begin
              bus.iccm_rden    = 1'b1;
              bus.iccm_rw_addr = bus.dma_addr[ICCM_BITS-1:2];
              state_nxt        = RMW_WR;
            end
          end else if (bus.ifc_rd_req) begin
            bus.ifc_rd_gnt   = 1'b1;
            bus.iccm_rden    = 1'b1;
            bus.iccm_rw_addr = bus.ifc_rd_addr;
          end
        end
        RMW_WR: begin
          bus.iccm_wren    = 1'b1;
          bus.iccm_rw_addr = addr_q[ICCM_BITS-1:2];
          bus.iccm_wr_size = {1'b0, SZ_W};
          bus.iccm_wr_data = {ecc_lo, merged, ecc_lo, merged};
          state_nxt        = IDLE;
        end
        RESP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    if (bus.ifc_rd_gnt || !bus.ifc_rd_req) consec_nxt = '0;
    else if (bus.dma_gnt && consec_cnt != CNT_MAX) consec_nxt = consec_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      consec_cnt <= '0;
      fetch_q    <= 1'b0;
      dma_rd_q   <= 1'b0;
      addr_q     <= '0;
      size_q     <= SZ_B;
      wdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      consec_cnt <= consec_nxt;
      fetch_q    <= bus.ifc_rd_gnt;
      dma_rd_q   <= bus.dma_gnt & ~bus.dma_wr & ~mis;
      if (bus.dma_gnt) begin
        addr_q  <= bus.dma_addr;
        size_q  <= req_size;
        wdata_q <= bus.dma_wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_ifu_iccm_arb_ctl.sv
// Directed bench for ifu_iccm_arb_ctl with a small behavioural ICCM array
// model and an independently derived SECDED reference.
module tb_ifu_iccm_arb_ctl;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  int   checks_total  = 0;
  int   checks_passed = 0;

  logic [38:0] mem [0:63];
  logic [5:0]  widx, rbase;

  ifu_iccm_arb_ctl_if #(.ICCM_BITS(16)) bus ();

  ifu_iccm_arb_ctl #(.ICCM_BITS(16), .DMA_MAX_CONSEC(4)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Check bits built from Hamming positions: data fills the non-power-of-two slots 3..38.
  function automatic logic [6:0] ref_ecc(input logic [31:0] d);
    logic [6:0] e;
    int         k;
    e = '0;
    k = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int j = 0; j < 6; j++) if (pos[j]) e[j] = e[j] ^ d[k];
        k++;
      end
    end
    e[6] = ^{d, e[5:0]};
    return e;
  endfunction

  assign widx  = bus.iccm_rw_addr[7:2];
  assign rbase = {bus.iccm_rw_addr[7:4], 2'b00};

  // Array model: word-indexed 39b lanes, 4-lane row returned one cycle after rden.
  always @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[1] = {ref_ecc(32'hDEAD_BEEF), 32'hDEAD_BEEF};
      bus.iccm_rd_data <= '0;
    end else begin
      if (bus.iccm_wren) begin
        mem[widx] = bus.iccm_wr_data[38:0];
        if (bus.iccm_wr_size == 3'd3) mem[widx + 6'd1] = bus.iccm_wr_data[77:39];
      end
      if (bus.iccm_rden)
        bus.iccm_rd_data <= {mem[rbase + 6'd3], mem[rbase + 6'd2], mem[rbase + 6'd1], mem[rbase]};
    end
  end

  task automatic checkOutput(input string tag, input logic [79:0] actual, input logic [79:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic ifc_req, input logic [15:0] ifc_byte,
                               input logic dreq, input logic dwr, input logic [15:0] daddr,
                               input logic [2:0] dsize, input logic [63:0] wdata);
    bus.ifc_rd_req  = ifc_req;
    bus.ifc_rd_addr = ifc_byte[15:2];
    bus.dma_req     = dreq;
    bus.dma_wr      = dwr;
    bus.dma_addr    = daddr;
    bus.dma_size    = dsize;
    bus.dma_wdata   = wdata;
  endtask

  task automatic nextCycle;
    @(negedge clk);
  endtask

  logic [31:0] merged_w;

  initial begin
    merged_w = 32'hDEAD_ABEF;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Reset: outputs quiet even with a fetch request present
    nextCycle(); applyStimulus(1, 16'h10, 0, 0, 0, 0, 0); #1;
    checkOutput("rst_ctl", {bus.ifc_rd_gnt, bus.dma_gnt, bus.iccm_rden, bus.iccm_wren,
                            bus.ifc_rd_valid, bus.dma_rvalid, bus.dma_err}, 0);
    checkOutput("rst_wdata", bus.iccm_wr_data, 0);
    checkOutput("rst_rdata", bus.dma_rdata, 0);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); rst_l = 1'b1;

    // Fetch-only read at 0x10
    nextCycle(); applyStimulus(1, 16'h10, 0, 0, 0, 0, 0); #1;
    checkOutput("fetch_gnt", {bus.ifc_rd_gnt, bus.iccm_rden, bus.dma_gnt}, 3'b110);
    checkOutput("fetch_addr", bus.iccm_rw_addr, 4);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("fetch_valid", {bus.ifc_rd_valid, bus.dma_rvalid, bus.iccm_rden}, 3'b100);

    // DMA DW write at 0x08
    nextCycle(); applyStimulus(0, 0, 1, 1, 16'h08, 3, 64'h1122_3344_5566_7788); #1;
    checkOutput("dw_wr_ctl", {bus.dma_gnt, bus.iccm_wren, bus.iccm_rden, bus.iccm_wr_size}, 6'b110_011);
    checkOutput("dw_wr_addr", bus.iccm_rw_addr, 2);
    checkOutput("dw_wr_data", bus.iccm_wr_data,
                {ref_ecc(32'h1122_3344), 32'h1122_3344, ref_ecc(32'h5566_7788), 32'h5566_7788});
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("dw_wr_norsp", bus.dma_rvalid, 0);

    // DW read back, then W read of the upper word at 0x0C
    nextCycle(); applyStimulus(0, 0, 1, 0, 16'h08, 3, 0); #1;
    checkOutput("dw_rd_ctl", {bus.dma_gnt, bus.iccm_rden, bus.iccm_wren}, 3'b110);
    nextCycle(); applyStimulus(0, 0, 1, 0, 16'h0C, 2, 0); #1;
    checkOutput("dw_rd_rsp", {bus.dma_rvalid, bus.dma_err}, 2'b10);
    checkOutput("dw_rd_data", bus.dma_rdata, 64'h1122_3344_5566_7788);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("w_rd_data", bus.dma_rdata, 64'h0000_0000_1122_3344);

    // W write at 0x10: data and ECC replicated in both lanes
    nextCycle(); applyStimulus(0, 0, 1, 1, 16'h10, 2, 64'h0000_0000_CAFE_F00D); #1;
    checkOutput("w_wr_ctl", {bus.iccm_wren, bus.iccm_wr_size}, 4'b1_010);
    checkOutput("w_wr_data", bus.iccm_wr_data,
                {ref_ecc(32'hCAFE_F00D), 32'hCAFE_F00D, ref_ecc(32'hCAFE_F00D), 32'hCAFE_F00D});

    // Byte RMW at 0x05 with fetch waiting; second DMA request held off during the write
    nextCycle(); applyStimulus(1, 16'h10, 1, 1, 16'h05, 0, 64'hAB); #1;
    checkOutput("rmw_rd", {bus.dma_gnt, bus.ifc_rd_gnt, bus.iccm_rden, bus.iccm_wren}, 4'b1010);
    checkOutput("rmw_rd_addr", bus.iccm_rw_addr, 1);
    nextCycle(); applyStimulus(1, 16'h10, 1, 0, 16'h0C, 2, 0); #1;
    checkOutput("rmw_wr_ctl", {bus.dma_gnt, bus.ifc_rd_gnt, bus.iccm_rden, bus.iccm_wren,
                               bus.iccm_wr_size}, 7'b0001_010);
    checkOutput("rmw_wr_addr", bus.iccm_rw_addr, 1);
    checkOutput("rmw_wr_data", bus.iccm_wr_data, {ref_ecc(merged_w), merged_w, ref_ecc(merged_w), merged_w});
    nextCycle(); #1;
    checkOutput("rmw_after_gnt", {bus.dma_gnt, bus.ifc_rd_gnt}, 2'b10);
    nextCycle(); applyStimulus(1, 16'h10, 0, 0, 0, 0, 0); #1;
    checkOutput("rmw_fetch_gnt", {bus.ifc_rd_gnt, bus.dma_rvalid}, 2'b11);
    checkOutput("rmw_w_rdata", bus.dma_rdata, 64'h1122_3344);
    nextCycle(); applyStimulus(0, 0, 1, 0, 16'h04, 2, 0); #1;
    checkOutput("rmw_rsp_excl", {bus.ifc_rd_valid, bus.dma_rvalid}, 2'b10);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("rmw_readback", bus.dma_rdata, {32'h0, merged_w});

    // Continuous DMA and fetch: D,D,D,D,F repeating
    for (int i = 0; i < 10; i++) begin
      nextCycle(); applyStimulus(1, 16'h10, 1, 0, 16'h00, 2, 0); #1;
      checkOutput($sformatf("rr_gnt%0d", i), {bus.dma_gnt, bus.ifc_rd_gnt}, (i % 5 == 4) ? 2'b01 : 2'b10);
      checkOutput($sformatf("rr_excl%0d", i), bus.ifc_rd_valid & bus.dma_rvalid, 0);
    end
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Misaligned W read at 0x06; fetch blocked during the error response
    nextCycle(); applyStimulus(1, 16'h10, 1, 0, 16'h06, 2, 0); #1;
    checkOutput("mis_gnt", {bus.dma_gnt, bus.ifc_rd_gnt, bus.iccm_rden, bus.iccm_wren}, 4'b1000);
    nextCycle(); applyStimulus(1, 16'h10, 0, 0, 0, 0, 0); #1;
    checkOutput("mis_rsp", {bus.dma_rvalid, bus.dma_err, bus.ifc_rd_gnt}, 3'b110);
    checkOutput("mis_rdata", bus.dma_rdata, 0);
    nextCycle(); #1;
    checkOutput("mis_then_fetch", {bus.ifc_rd_gnt, bus.dma_err}, 2'b10);

    // Misaligned H write at 0x01: no array write, error response
    nextCycle(); applyStimulus(0, 0, 1, 1, 16'h01, 1, 64'h1234); #1;
    checkOutput("mis_h_gnt", {bus.dma_gnt, bus.iccm_rden, bus.iccm_wren}, 3'b100);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("mis_h_rsp", {bus.dma_rvalid, bus.dma_err, bus.iccm_wren}, 3'b110);

    // Reset in RMW_WR abandons the write
    nextCycle(); applyStimulus(0, 0, 1, 1, 16'h05, 0, 64'h55); #1;
    checkOutput("rrst_rd", bus.iccm_rden, 1);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("rrst_wr_before", bus.iccm_wren, 1);
    rst_l = 1'b0; #1;
    checkOutput("rrst_quiet", {bus.iccm_wren, bus.iccm_rden, bus.dma_gnt, bus.ifc_rd_gnt,
                               bus.dma_rvalid, bus.dma_err, bus.ifc_rd_valid}, 0);
    checkOutput("rrst_wdata", bus.iccm_wr_data, 0);
    nextCycle(); rst_l = 1'b1;
    for (int i = 0; i < 2; i++) begin
      nextCycle(); #1;
      checkOutput($sformatf("rrst_idle%0d", i), {bus.iccm_wren, bus.iccm_rden, bus.dma_rvalid}, 0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
